// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Arbitrates the single system memory port (ROM/RAM with a registered one-cycle
// read) between the chroni video fetcher and the CPU. Chroni has real-time
// priority. Each granted access is a single 8-bit read or write and finishes
// with a one-cycle ack pulse to its owner. Only one access is ever in flight.
//
// Optional build macro:
//   BUS_ARB_FAIRNESS_EN - when defined, a starvation guard counts chroni grants
//                         made while the CPU is waiting. Once CPU_MAX_WAIT is
//                         reached, the next grant goes to the CPU. When the
//                         macro is undefined, chroni has strict priority.
//
// Parameters:
//   ADDR_W        memory address width (default 14)
//   CPU_MAX_WAIT  chroni grants allowed while the CPU waits, 1..255 (default 8)
//
// Ports:
//   sys_clk        in   system clock; all logic runs on its rising edge
//   reset          in   asynchronous, active-high reset
//   chroni_addr    in   [13:0] chroni read address (zero-extended/truncated)
//   chroni_rd_req  in   chroni read request (level)
//   chroni_rd_ack  out  one-cycle pulse; chroni_data is valid while it is high
//   chroni_data    out  [7:0] registered chroni read data
//   cpu_addr       in   [15:0] CPU address; the low ADDR_W bits are used
//   cpu_rd_req     in   CPU read request (level)
//   cpu_wr_req     in   CPU write request (level); wins over cpu_rd_req
//   cpu_wr_data    in   [7:0] write data, sampled at grant
//   cpu_ack        out  one-cycle completion pulse for a CPU read or write
//   cpu_data       out  [7:0] registered CPU read data, valid with cpu_ack
//   mem_addr       out  [ADDR_W-1:0] memory address
//   mem_we         out  one-cycle memory write strobe
//   mem_wr_data    out  [7:0] memory write data
//   mem_rd_data    in   [7:0] memory q, valid one edge after the address edge
//   dbg_state      out  [2:0] current FSM state encoding (for observation)
//
// Handshake: a requester raises its level request and holds it until it sees
// its ack high; it then drops the request on that same edge. The arbiter never
// samples requests in ACK, and IDLE samples one edge later, so a completed
// request is never granted twice. A request dropped after grant still
// completes, and its ack still pulses.
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [13:0]       chroni_addr,
  input  logic              chroni_rd_req,
  output logic              chroni_rd_ack,
  output logic [7:0]        chroni_data,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [7:0]        cpu_wr_data,
  output logic              cpu_ack,
  output logic [7:0]        cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    ACK     = 3'd3,
    WR      = 3'd4
  } state_t;

  state_t state;
  logic   owner_cpu;  // 1: current access belongs to the CPU, 0: to chroni

  // Catch an out-of-range wait limit at elaboration time in every build.
  if (CPU_MAX_WAIT < 1 || CPU_MAX_WAIT > 255) begin : g_bad_cpu_max_wait
    $error("bus_arbiter: CPU_MAX_WAIT must be in 1..255");
  end

  logic [ADDR_W-1:0] chroni_addr_w;
  logic [ADDR_W-1:0] cpu_addr_w;
  logic              cpu_pend;
  logic              force_cpu;
  logic              grant_chroni;

  assign chroni_addr_w = ADDR_W'(chroni_addr);
  assign cpu_addr_w    = ADDR_W'(cpu_addr);
  assign cpu_pend      = cpu_rd_req | cpu_wr_req;
  assign grant_chroni  = chroni_rd_req & ~force_cpu;
  assign dbg_state     = state;

`ifdef BUS_ARB_FAIRNESS_EN
  localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

  // Count of consecutive chroni grants made while the CPU was waiting. The
  // counter only moves on grants (in IDLE). It stops at MAX_WAIT because the
  // next grant then goes to the CPU and clears it.
  logic [7:0] fair_cnt;

  assign force_cpu = cpu_pend & (fair_cnt >= MAX_WAIT);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      fair_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (grant_chroni) begin
        fair_cnt <= cpu_pend ? fair_cnt + 8'd1 : 8'd0;
      end else if (cpu_pend) begin
        fair_cnt <= 8'd0;
      end
    end
  end
`else
  assign force_cpu = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner_cpu     <= 1'b0;
      chroni_rd_ack <= 1'b0;
      cpu_ack       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= 8'd0;
      chroni_data   <= 8'd0;
      cpu_data      <= 8'd0;
    end else begin
      // Acks and the write strobe are single-cycle pulses. The data and
      // address registers keep their values unless they are written below.
      chroni_rd_ack <= 1'b0;
      cpu_ack       <= 1'b0;
      mem_we        <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_chroni) begin
            mem_addr  <= chroni_addr_w;
            owner_cpu <= 1'b0;
            state     <= RD_ADDR;
          end else if (cpu_pend) begin
            mem_addr  <= cpu_addr_w;
            owner_cpu <= 1'b1;
            // If both the read and the write are requested, do the write.
            if (cpu_wr_req) begin
              mem_we      <= 1'b1;
              mem_wr_data <= cpu_wr_data;
              state       <= WR;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        // The memory registers mem_addr on this edge; q is ready one edge later.
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          if (owner_cpu) begin
            cpu_data <= mem_rd_data;
            cpu_ack  <= 1'b1;
          end else begin
            chroni_data   <= mem_rd_data;
            chroni_rd_ack <= 1'b1;
          end
          state <= ACK;
        end
        WR: begin
          cpu_ack <= 1'b1;
          state   <= ACK;
        end
        // Requests are not sampled here: the owner is still dropping its request.
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int ADDR_W       = 14;
  localparam int CPU_MAX_WAIT = 3;
  localparam int W            = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  // DUT signals
  logic [13:0]       chroni_addr   = '0;
  logic              chroni_rd_req = 1'b0;
  logic              chroni_rd_ack;
  logic [7:0]        chroni_data;
  logic [15:0]       cpu_addr      = '0;
  logic              cpu_rd_req    = 1'b0;
  logic              cpu_wr_req    = 1'b0;
  logic [7:0]        cpu_wr_data   = '0;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;
  logic [2:0]        dbg_state;

  bus_arbiter #(
    .ADDR_W       (ADDR_W),
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .chroni_addr   (chroni_addr),
    .chroni_rd_req (chroni_rd_req),
    .chroni_rd_ack (chroni_rd_ack),
    .chroni_data   (chroni_data),
    .cpu_addr      (cpu_addr),
    .cpu_rd_req    (cpu_rd_req),
    .cpu_wr_req    (cpu_wr_req),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_ack       (cpu_ack),
    .cpu_data      (cpu_data),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Memory model: synchronous write, registered one-cycle read. A separate
  // preload port lets the bench seed contents.
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pre_we   = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = '0;

  always @(posedge sys_clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;
  int chroni_acks = 0;
  int cpu_acks    = 0;

  logic [W-1:0] chroni_exp_q[$];
  logic [W:0]   cpu_exp_q[$];    // bit W set: read, so data is compared

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ack monitor, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (chroni_rd_ack || cpu_ack)
        check("ack_exclusive", {31'd0, chroni_rd_ack & cpu_ack}, 32'd0);
      if (chroni_rd_ack) begin
        chroni_acks++;
        check("chroni_exp_avail", {31'd0, chroni_exp_q.size() > 0}, 32'd1);
        if (chroni_exp_q.size() > 0) check("chroni_data", chroni_data, chroni_exp_q.pop_front());
      end
      if (cpu_ack) begin
        logic [W:0] e;
        cpu_acks++;
        check("cpu_exp_avail", {31'd0, cpu_exp_q.size() > 0}, 32'd1);
        if (cpu_exp_q.size() > 0) begin
          e = cpu_exp_q.pop_front();
          if (e[W]) check("cpu_data", cpu_data, e[W-1:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic chroni_read(input logic [13:0] a, input logic [7:0] d, input string tag);
    int n;
    chroni_addr   = a;
    chroni_rd_req = 1'b1;
    chroni_exp_q.push_back(d);
    tick();
    check({tag, "_mem_addr"}, mem_addr, a);
    n = 1;
    while (!chroni_rd_ack && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 3);
    chroni_rd_req = 1'b0;
    tick();
    check({tag, "_ack_single"}, chroni_rd_ack, 0);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] d, input string tag);
    int n;
    cpu_addr   = a;
    cpu_rd_req = 1'b1;
    cpu_exp_q.push_back({1'b1, d});
    tick();
    check({tag, "_mem_addr"}, mem_addr, a[13:0]);
    n = 1;
    while (!cpu_ack && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 3);
    cpu_rd_req = 1'b0;
    tick();
    check({tag, "_ack_single"}, cpu_ack, 0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic with_rd,
                           input string tag);
    cpu_addr    = a;
    cpu_wr_data = d;
    cpu_wr_req  = 1'b1;
    cpu_rd_req  = with_rd;
    cpu_exp_q.push_back({1'b0, 8'h00});
    tick();
    check({tag, "_we_high"}, mem_we, 1);
    check({tag, "_mem_addr"}, mem_addr, a[13:0]);
    check({tag, "_wr_data"}, mem_wr_data, d);
    check({tag, "_ack_early"}, cpu_ack, 0);
    tick();
    check({tag, "_we_low"}, mem_we, 0);
    check({tag, "_ack"}, cpu_ack, 1);
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
    tick();
    check({tag, "_ack_single"}, cpu_ack, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ch_t, cpu_t, n_ch, ch_at_cpu, a0, n;
    logic cpu_seen;

    // Reset state
    repeat (2) tick();
    check("rst_chroni_ack", chroni_rd_ack, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr_data", mem_wr_data, 0);
    check("rst_chroni_data", chroni_data, 0);
    check("rst_cpu_data", cpu_data, 0);
    check("rst_state", dbg_state, 0);
    preload(14'h0123, 8'hA5);
    preload(14'h3FFF, 8'h5A);
    reset = 1'b0;
    tick();

    // Chroni read, then values hold while idle
    chroni_read(14'h0123, 8'hA5, "chroni_rd");
    repeat (3) tick();
    check("hold_chroni_data", chroni_data, 8'hA5);
    check("hold_mem_addr", mem_addr, 14'h0123);
    check("hold_state_idle", dbg_state, 0);

    // CPU write, then read back
    cpu_write(16'h4010, 8'h3C, 1'b0, "cpu_wr");
    cpu_read(16'h0010, 8'h3C, "cpu_rd");

    // Simultaneous requests: chroni first, CPU four cycles later
    chroni_addr   = 14'h0123;
    cpu_addr      = 16'h0010;
    chroni_exp_q.push_back(8'hA5);
    cpu_exp_q.push_back({1'b1, 8'h3C});
    chroni_rd_req = 1'b1;
    cpu_rd_req    = 1'b1;
    ch_t = 0;
    cpu_t = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (chroni_rd_ack && ch_t == 0) begin ch_t = i; chroni_rd_req = 1'b0; end
      if (cpu_ack && cpu_t == 0) begin cpu_t = i; cpu_rd_req = 1'b0; end
      if (ch_t != 0 && cpu_t != 0) break;
    end
    check("simul_chroni_ack_cycle", ch_t, 3);
    check("simul_cpu_ack_cycle", cpu_t, 7);
    tick();

    // Chroni streaming continuously while the CPU waits
    chroni_addr   = 14'h0123;
    cpu_addr      = 16'h0010;
    cpu_exp_q.push_back({1'b1, 8'h3C});
    chroni_rd_req = 1'b1;
    cpu_rd_req    = 1'b1;
    n_ch = 0;
    ch_at_cpu = -1;
    cpu_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (chroni_rd_ack) begin
        n_ch++;
        chroni_exp_q.push_back(8'hA5);
        if (n_ch == 100) chroni_rd_req = 1'b0;
      end
      if (cpu_ack) begin
        cpu_seen = 1'b1;
        ch_at_cpu = n_ch;
        cpu_rd_req = 1'b0;
        chroni_rd_req = 1'b0;
      end
      if (cpu_seen || n_ch == 100) break;
    end
`ifdef BUS_ARB_FAIRNESS_EN
    check("fair_cpu_acked", cpu_seen, 1);
    check("fair_chroni_acks_before_cpu", ch_at_cpu, CPU_MAX_WAIT);
`else
    check("strict_cpu_starved", cpu_seen, 0);
    check("strict_chroni_acks", n_ch, 100);
    n = 0;
    while (!cpu_ack && n < 12) begin
      tick();
      n++;
    end
    check("strict_cpu_served_after_chroni", cpu_ack, 1);
    cpu_rd_req = 1'b0;
`endif
    repeat (2) tick();

    // Asynchronous reset while a chroni read is in RD_DATA
    chroni_addr   = 14'h0123;
    chroni_rd_req = 1'b1;
    tick();
    tick();
    check("abort_in_rd_data", dbg_state, 2);
    a0 = chroni_acks;
    #1 reset = 1'b1;
    #1;
    check("abort_chroni_ack", chroni_rd_ack, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_chroni_data", chroni_data, 0);
    check("abort_state", dbg_state, 0);
    chroni_rd_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    check("abort_no_ack", chroni_acks, a0);
    chroni_read(14'h3FFF, 8'h5A, "post_reset_rd");

    // CPU read and write both high: write wins, then read back
    cpu_write(16'hC200, 8'h77, 1'b1, "cpu_rdwr");
    cpu_read(16'h0200, 8'h77, "cpu_rdwr_readback");

    // Chroni drops its request one cycle after grant
    chroni_addr   = 14'h0123;
    chroni_rd_req = 1'b1;
    chroni_exp_q.push_back(8'hA5);
    a0 = chroni_acks;
    tick();
    chroni_rd_req = 1'b0;
    n = 1;
    while (!chroni_rd_ack && n < 12) begin
      tick();
      n++;
    end
    check("drop_latency", n, 3);
    repeat (8) tick();
    check("drop_single_ack", chroni_acks, a0 + 1);
    check("drop_state_idle", dbg_state, 0);

    // Every expected result was consumed
    check("chroni_q_empty", chroni_exp_q.size(), 0);
    check("cpu_q_empty", cpu_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbiter and sequencer for the shared system memory port (ROM/RAM with a registered 1-cycle read) between the chroni video fetcher and the CPU. It sits in `system` between the requesters and the memory instance, replacing ad-hoc bus sequencing. Chroni has real-time priority, and a starvation guard can be compiled in to protect the CPU. Each granted access is one 8-bit read or write, completed with a one-cycle ack pulse.

## Interface

- `ADDR_W`, default 14: memory address width.
- `CPU_MAX_WAIT`, default 8: number of consecutive chroni grants allowed while the CPU is pending (fairness build only), range 1..255.
- `sys_clk` in 1: system clock, 100 MHz; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `chroni_addr` in 14: chroni read address; zero-extended or truncated to `ADDR_W`.
- `chroni_rd_req` in 1: chroni read request, level, held until ack.
- `chroni_rd_ack` out 1: one-cycle pulse; `chroni_data` is valid while it is high.
- `chroni_data` out 8: registered read data.
- `cpu_addr` in 16: CPU address; the low `ADDR_W` bits are used.
- `cpu_rd_req` in 1: CPU read request, level.
- `cpu_wr_req` in 1: CPU write request, level.
- `cpu_wr_data` in 8: write data, sampled at grant.
- `cpu_ack` out 1: one-cycle completion pulse for a read or a write.
- `cpu_data` out 8: registered read data, valid while `cpu_ack` is high.
- `mem_addr` out `ADDR_W`: address to the memory.
- `mem_we` out 1: write strobe, one cycle.
- `mem_wr_data` out 8: write data to the memory.
- `mem_rd_data` in 8: memory q, valid one edge after the address edge.

## Operation

- **States:** IDLE, RD_ADDR, RD_DATA, ACK, WR.
- **IDLE:** samples requests and grants at most one per edge.
  - Chroni is granted first if `chroni_rd_req` is high.
  - Otherwise the CPU is granted if `cpu_wr_req` or `cpu_rd_req` is high.
  - On grant: register `mem_addr` and latch the owner (chroni or cpu).
  - A read moves to RD_ADDR.
  - A write moves to WR, with `mem_we`=1 and `mem_wr_data`=`cpu_wr_data`.
- **RD_ADDR:** memory samples `mem_addr`; go to RD_DATA.
- **RD_DATA:** capture `mem_rd_data` into the owner's data register and raise the owner's ack; go to ACK.
- **WR:** `mem_we`=0 and `cpu_ack`=1; go to ACK.
- **ACK:** drop the ack and go to IDLE. Requests are not sampled in this state.
- **Requester rule:** deassert the request on the edge that sees ack high. Because IDLE samples one edge later, a completed request is never re-granted.
- **CPU rd and wr both high:** treated as a write; the read is ignored.
- **Request dropped after grant:** the access still completes and the ack still pulses.
- **Hold behaviour:** `mem_addr`, `chroni_data` and `cpu_data` hold their last values when idle.
- **Reset (asynchronous, any state):** state goes to IDLE; `chroni_rd_ack`, `cpu_ack` and `mem_we` go to 0; `mem_addr`, `mem_wr_data`, `chroni_data` and `cpu_data` go to 0; the fairness counter goes to 0. An in-flight access is abandoned with no ack.

## Timing

- **Read:** request sampled at edge T.
  - `mem_addr` is valid after T.
  - Memory q is valid after T+1.
  - Data is captured and ack is high from T+2 to T+3.
  - IDLE is re-entered at T+3.
  - The next grant is sampled at T+4.
  - Latency is 3 cycles from request to ack; throughput is 1 access per 4 cycles.
- **Write:** grant at T; `mem_we` is high T..T+1; ack is high T+1..T+2; next grant is sampled at T+3.
- **Output registers:** all outputs are registered, with no combinational path from a request to any output.

## Configuration

- **`BUS_ARB_FAIRNESS_EN` defined:**
  - An 8-bit counter increments on each chroni grant made while a CPU request is pending.
  - When it reaches `CPU_MAX_WAIT`, the next IDLE grant goes to the CPU even if chroni is requesting.
  - The counter clears on any CPU grant, or when no CPU request is pending at a grant.
- **Undefined:** strict chroni priority, no counter logic; the CPU can starve indefinitely.

## Test plan

- **Chroni read:** preload mem[0x0123]=0xA5; raise `chroni_rd_req` with addr 0x0123 → `mem_addr`=0x0123 after 1 edge, `chroni_rd_ack` pulses exactly once 3 cycles after the request with `chroni_data`=0xA5.
- **CPU write then read:** write 0x3C to `cpu_addr` 0x4010 → `mem_we` high one cycle with `mem_addr`=0x0010 and `cpu_ack` one cycle later. A read of 0x0010 then returns `cpu_data`=0x3C.
- **Simultaneous requests:** chroni and CPU requests both raised in the same cycle → chroni is acked first and the CPU ack follows 4 cycles later. No overlap of acks, never two grants in flight.
- **Fairness:** chroni requests continuously with the CPU pending, `CPU_MAX_WAIT`=3 → with `BUS_ARB_FAIRNESS_EN` the CPU is acked after exactly 3 chroni acks; without it the CPU receives no ack during 100 chroni accesses.
- **Reset mid-access:** assert `reset` in RD_DATA → acks and `mem_we` are 0 immediately (asynchronously) and no ack is ever issued for that access. After release, a new chroni read completes normally in 3 cycles.
- **Protocol edges:** `cpu_rd_req` and `cpu_wr_req` both high → a write is performed. Chroni drops its request one cycle after grant → the ack still pulses once and no second access is issued.
